pico_io_bus: RTL and testbench

- Parametrised PicoBlaze (KCPSM6) I/O bus controller for NCH peripheral channels.
- Decodes port_id into per-channel select, read and write strobes, and drives the sub-address.
- Multiplexes and registers channel read data onto in_port.
- Adds an interrupt controller with per-channel pending/mask registers and an interrupt/interrupt_ack handshake FSM. Sits between the processor and the RTC/VGA/keyboard/sound peripherals.

---
 rtl/pico_io_bus_if.sv | 32 +++
 rtl/pico_io_bus.sv | 172 +++++++++++++++++
 tb/tb_pico_io_bus.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pico_io_bus_if.sv
//------------------------------------------------------------------------------
// Module      : pico_io_bus_if
// Description : KCPSM6 processor-side I/O bus (port address, data, strobes,
//               interrupt handshake).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pico_io_bus_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, out_port, write_strobe, k_write_strobe, read_strobe,
        output interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, out_port, write_strobe, k_write_strobe, read_strobe,
        input  interrupt_ack,
        output in_port, interrupt
    );
endinterface

`default_nettype wire

// File: rtl/pico_io_bus.sv
//------------------------------------------------------------------------------
// Module      : pico_io_bus
// Description : KCPSM6 I/O bus controller: channel decode, registered strobes
//               and read mux, plus a pending/mask interrupt controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pico_io_bus #(
    parameter int         NCH          = 4,
    parameter int         SUB_BITS     = 4,
    parameter int         CTRL_IDX     = 15,
    parameter int         IRQ_EDGE     = 1,
    parameter logic [7:0] UNMAPPED_VAL = 8'h00
) (
    input  logic                clk,
    input  logic                kcpsm6_reset,
    pico_io_bus_if.slave        bus,
    input  logic [NCH*8-1:0]    ch_rdata,
    input  logic [NCH-1:0]      irq_in,
    output logic [NCH-1:0]      ch_sel,
    output logic [NCH-1:0]      ch_wr,
    output logic [NCH-1:0]      ch_rd,
    output logic [SUB_BITS-1:0] ch_addr,
    output logic [7:0]          ch_wdata
);

    localparam int IW = 8 - SUB_BITS;

    localparam logic [IW-1:0]       c_ctrl_idx = IW'(CTRL_IDX);
    localparam logic [SUB_BITS-1:0] c_sub_mask = SUB_BITS'(0);
    localparam logic [SUB_BITS-1:0] c_sub_pend = SUB_BITS'(1);
    localparam logic [SUB_BITS-1:0] c_sub_info = SUB_BITS'(2);
    localparam logic [7:0]          c_info     = {4'h0, 4'(NCH)};

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_svc  = 2'd2;

    logic [IW-1:0]       w_idx;
    logic [SUB_BITS-1:0] w_sub;
    logic                w_wr;
    logic                w_ctrl;
    logic [NCH-1:0]      w_sel;
    logic [7:0]          w_rd_mux;
    logic [NCH-1:0]      w_irq_set;
    logic [NCH-1:0]      w_w1c;
    logic                w_act;

    logic [7:0]          r_in_port;
    logic [NCH-1:0]      r_ch_wr;
    logic [NCH-1:0]      r_ch_rd;
    logic [SUB_BITS-1:0] r_ch_addr;
    logic [7:0]          r_ch_wdata;
    logic [NCH-1:0]      r_mask;
    logic [NCH-1:0]      r_pend;
    logic [NCH-1:0]      r_irq_prev;
    logic [1:0]          r_state;
    logic                r_interrupt;

    assign w_idx  = bus.port_id[7:SUB_BITS];
    assign w_sub  = bus.port_id[SUB_BITS-1:0];
    assign w_wr   = bus.write_strobe | bus.k_write_strobe;
    assign w_ctrl = (w_idx == c_ctrl_idx);
    assign w_act  = |(r_pend & r_mask);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_sel
            assign w_sel[gi] = (w_idx == IW'(gi));
        end

        if (IRQ_EDGE != 0) begin : g_irq_edge
            assign w_irq_set = irq_in & ~r_irq_prev;
        end else begin : g_irq_level
            assign w_irq_set = irq_in;
        end
    endgenerate

    assign w_w1c = (w_wr && w_ctrl && (w_sub == c_sub_pend)) ?
                   bus.out_port[NCH-1:0] : '0;

    // CTRL_IDX >= NCH, so channel and control decodes never overlap
    always_comb begin
        w_rd_mux = UNMAPPED_VAL;
        for (int i = 0; i < NCH; i++) begin
            if (w_sel[i]) begin
                w_rd_mux = ch_rdata[8*i +: 8];
            end
        end
        if (w_ctrl) begin
            case (w_sub)
                c_sub_mask: w_rd_mux = 8'(r_mask);
                c_sub_pend: w_rd_mux = 8'(r_pend);
                c_sub_info: w_rd_mux = c_info;
                default:    w_rd_mux = UNMAPPED_VAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (kcpsm6_reset) begin
            r_in_port  <= UNMAPPED_VAL;
            r_ch_wr    <= '0;
            r_ch_rd    <= '0;
            r_ch_addr  <= '0;
            r_ch_wdata <= '0;
            r_mask     <= '0;
            r_pend     <= '0;
            r_irq_prev <= '0;
        end else begin
            r_in_port  <= w_rd_mux;
            r_ch_wr    <= w_wr ? w_sel : '0;
            r_ch_rd    <= bus.read_strobe ? w_sel : '0;
            if (w_wr) begin
                r_ch_addr  <= w_sub;
                r_ch_wdata <= bus.out_port;
            end
            if (w_wr && w_ctrl && (w_sub == c_sub_mask)) begin
                r_mask <= bus.out_port[NCH-1:0];
            end
            // a new capture overrides a same-cycle W1C on that bit
            r_pend     <= (r_pend & ~w_w1c) | w_irq_set;
            r_irq_prev <= irq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (kcpsm6_reset) begin
            r_state     <= c_st_idle;
            r_interrupt <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_act) begin
                        r_state     <= c_st_req;
                        r_interrupt <= 1'b1;
                    end
                end
                c_st_req: begin
                    if (bus.interrupt_ack) begin
                        r_state     <= c_st_svc;
                        r_interrupt <= 1'b0;
                    end else if (!w_act) begin
                        r_state     <= c_st_idle;
                        r_interrupt <= 1'b0;
                    end
                end
                c_st_svc: begin
                    // must see act low before a new request can be raised
                    if (!w_act) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_interrupt <= 1'b0;
                end
            endcase
        end
    end

    assign ch_sel        = w_sel;
    assign ch_wr         = r_ch_wr;
    assign ch_rd         = r_ch_rd;
    assign ch_addr       = r_ch_addr;
    assign ch_wdata      = r_ch_wdata;
    assign bus.in_port   = r_in_port;
    assign bus.interrupt = r_interrupt;

endmodule

`default_nettype wire

// File: tb/tb_pico_io_bus.sv
//------------------------------------------------------------------------------
// Module      : tb_pico_io_bus
// Description : Self-checking bench for pico_io_bus (directed table, corner
//               sequence, randomized run against a reference model).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pico_io_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ch_rdata;
    logic [3:0]  irq_in;
    logic [3:0]  ch_sel, ch_wr, ch_rd, ch_addr;
    logic [7:0]  ch_wdata;

    int n_vec = 0;
    int n_err = 0;

    pico_io_bus_if bus ();

    pico_io_bus #(
        .NCH(4), .SUB_BITS(4), .CTRL_IDX(15), .IRQ_EDGE(1), .UNMAPPED_VAL(8'h00)
    ) dut (
        .clk(clk), .kcpsm6_reset(rst), .bus(bus),
        .ch_rdata(ch_rdata), .irq_in(irq_in), .ch_sel(ch_sel),
        .ch_wr(ch_wr), .ch_rd(ch_rd), .ch_addr(ch_addr), .ch_wdata(ch_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] pid, dout;
        logic       ws, kws, rs;
        logic [3:0] irq;
        logic       ack;
        logic [3:0] e_wr, e_rd, e_addr;
        logic [7:0] e_wdata, e_inp;
        logic       e_int;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(logic r, logic [7:0] pid, logic [7:0] dout,
                                logic ws, logic kws, logic rs, logic [3:0] irq,
                                logic ack, logic [3:0] e_wr, logic [3:0] e_rd,
                                logic [3:0] e_addr, logic [7:0] e_wdata,
                                logic [7:0] e_inp, logic e_int);
        vec_t v;
        v.rst = r; v.pid = pid; v.dout = dout; v.ws = ws; v.kws = kws; v.rs = rs;
        v.irq = irq; v.ack = ack; v.e_wr = e_wr; v.e_rd = e_rd; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_inp = e_inp; v.e_int = e_int;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] sel_of(input logic [7:0] p);
        logic [3:0] hi;
        hi = p[7:4];
        return (hi < 4'd4) ? 4'(1 << hi) : 4'h0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [7:0] pid, input logic [7:0] dout,
                         input logic ws, input logic kws, input logic rs,
                         input logic [3:0] irq, input logic ack);
        rst = r; bus.port_id = pid; bus.out_port = dout; bus.write_strobe = ws;
        bus.k_write_strobe = kws; bus.read_strobe = rs; irq_in = irq;
        bus.interrupt_ack = ack;
    endtask

    // Reference model: software-visible registers and the request phase
    // (0 none, 1 requesting, 2 being serviced) predicted from the rules.
    logic [3:0] m_mask, m_pend, m_prev, m_wr, m_rd, m_addr;
    logic [7:0] m_wdata, m_inp;
    int         m_phase;

    task automatic model_edge();
        int         idx, sub;
        logic       wr, act;
        logic [7:0] rd;
        logic [3:0] clr;
        idx = int'(bus.port_id) / 16;
        sub = int'(bus.port_id) % 16;
        wr  = bus.write_strobe | bus.k_write_strobe;
        if (idx < 4)                     rd = ch_rdata[idx*8 +: 8];
        else if (idx == 15 && sub == 0)  rd = {4'h0, m_mask};
        else if (idx == 15 && sub == 1)  rd = {4'h0, m_pend};
        else if (idx == 15 && sub == 2)  rd = 8'd4;
        else                             rd = 8'h00;
        if (rst) begin
            m_mask = 0; m_pend = 0; m_prev = 0; m_wr = 0; m_rd = 0;
            m_addr = 0; m_wdata = 0; m_inp = 8'h00; m_phase = 0;
        end else begin
            act   = (m_pend & m_mask) != 0;
            m_inp = rd;
            m_wr  = (wr && idx < 4) ? 4'(1 << idx) : 4'h0;
            m_rd  = (bus.read_strobe && idx < 4) ? 4'(1 << idx) : 4'h0;
            if (wr) begin
                m_addr  = 4'(sub);
                m_wdata = bus.out_port;
            end
            if (m_phase == 0 && act)                          m_phase = 1;
            else if (m_phase == 1 && bus.interrupt_ack)       m_phase = 2;
            else if (m_phase == 1 && !act)                    m_phase = 0;
            else if (m_phase == 2 && !act)                    m_phase = 0;
            clr = (wr && idx == 15 && sub == 1) ? bus.out_port[3:0] : 4'h0;
            if (wr && idx == 15 && sub == 0) m_mask = bus.out_port[3:0];
            m_pend = (m_pend & ~clr) | (irq_in & ~m_prev);
            m_prev = irq_in;
        end
    endtask

    initial begin
        ch_rdata = 32'h33775C11;
        drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

        //            rst pid    dout   ws kws rs irq  ack  wr   rd   adr  wdata  inp    int
        tbl[0]  = mk(1, 8'h00, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0);
        tbl[1]  = mk(0, 8'h23, 8'hA5, 1, 0, 0, 4'h0, 0, 4'h4, 4'h0, 4'h3, 8'hA5, 8'h77, 0);
        tbl[2]  = mk(0, 8'h23, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h3, 8'hA5, 8'h77, 0);
        tbl[3]  = mk(0, 8'h31, 8'h5A, 0, 1, 0, 4'h0, 0, 4'h8, 4'h0, 4'h1, 8'h5A, 8'h33, 0);
        tbl[4]  = mk(0, 8'h10, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h1, 8'h5A, 8'h5C, 0);
        tbl[5]  = mk(0, 8'h10, 8'h00, 0, 0, 1, 4'h0, 0, 4'h0, 4'h2, 4'h1, 8'h5A, 8'h5C, 0);
        tbl[6]  = mk(0, 8'h70, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h1, 8'h5A, 8'h00, 0);
        tbl[7]  = mk(0, 8'h70, 8'h99, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h99, 8'h00, 0);
        tbl[8]  = mk(0, 8'hF0, 8'h05, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h05, 8'h00, 0);
        tbl[9]  = mk(0, 8'hF0, 8'h00, 0, 0, 0, 4'h4, 0, 4'h0, 4'h0, 4'h0, 8'h05, 8'h05, 0);
        tbl[10] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h05, 8'h04, 1);
        tbl[11] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 8'h05, 8'h04, 0);
        tbl[12] = mk(0, 8'hF1, 8'h04, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h1, 8'h04, 8'h04, 0);
        tbl[13] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h1, 8'h04, 8'h00, 0);
        tbl[14] = mk(0, 8'hF0, 8'h01, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h01, 8'h05, 0);
        tbl[15] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h2, 0, 4'h0, 4'h0, 4'h0, 8'h01, 8'h00, 0);
        tbl[16] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h01, 8'h02, 0);
        tbl[17] = mk(0, 8'hF0, 8'h03, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h03, 8'h01, 0);
        tbl[18] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h03, 8'h02, 1);
        tbl[19] = mk(0, 8'hF2, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h03, 8'h04, 1);
        tbl[20] = mk(0, 8'hF1, 8'h02, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h1, 8'h02, 8'h02, 1);
        tbl[21] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h1, 8'h02, 8'h00, 0);
        tbl[22] = mk(0, 8'hF1, 8'h01, 1, 0, 0, 4'h1, 0, 4'h0, 4'h0, 4'h1, 8'h01, 8'h00, 0);
        tbl[23] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h1, 0, 4'h0, 4'h0, 4'h1, 8'h01, 8'h01, 1);
        tbl[24] = mk(0, 8'hF2, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h1, 8'h01, 8'h04, 1);
        tbl[25] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'hF, 0, 4'h0, 4'h0, 4'h1, 8'h01, 8'h01, 1);
        tbl[26] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h1, 8'h01, 8'h0F, 1);
        tbl[27] = mk(1, 8'h23, 8'hFF, 1, 0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0);
        tbl[28] = mk(0, 8'hF0, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0);
        tbl[29] = mk(0, 8'hF1, 8'h00, 0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 8'h00, 8'h00, 0);

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].rst, tbl[i].pid, tbl[i].dout, tbl[i].ws, tbl[i].kws,
                  tbl[i].rs, tbl[i].irq, tbl[i].ack);
            #1;
            chk($sformatf("tbl%0d_sel", i), 32'(ch_sel), 32'(sel_of(tbl[i].pid)));
            cyc();
            chk($sformatf("tbl%0d_wr", i),    32'(ch_wr),         32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_rd", i),    32'(ch_rd),         32'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_addr", i),  32'(ch_addr),       32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_wdata", i), 32'(ch_wdata),      32'(tbl[i].e_wdata));
            chk($sformatf("tbl%0d_inp", i),   32'(bus.in_port),   32'(tbl[i].e_inp));
            chk($sformatf("tbl%0d_int", i),   32'(bus.interrupt), 32'(tbl[i].e_int));
        end

        // New source during service must not re-raise interrupt
        drive(1, 8'h00, 8'h00, 0, 0, 0, 4'h0, 0); cyc();
        drive(0, 8'hF0, 8'h0F, 1, 0, 0, 4'h0, 0); cyc();
        drive(0, 8'hF1, 8'h00, 0, 0, 0, 4'h8, 0); cyc();
        irq_in = 4'h0;
        for (int k = 0; k < 5 && !bus.interrupt; k++) cyc();
        chk("seq_raise", 32'(bus.interrupt), 32'd1);
        bus.interrupt_ack = 1'b1; cyc(); bus.interrupt_ack = 1'b0;
        chk("seq_ack_drop", 32'(bus.interrupt), 32'd0);
        irq_in = 4'h1; cyc(); irq_in = 4'h0; cyc(); cyc();
        chk("seq_svc_hold", 32'(bus.interrupt), 32'd0);
        chk("seq_pend9", 32'(bus.in_port), 32'h09);
        drive(0, 8'hF1, 8'h08, 1, 0, 0, 4'h0, 0); cyc();
        bus.write_strobe = 1'b0; cyc();
        chk("seq_partial_clr", 32'(bus.interrupt), 32'd0);
        chk("seq_pend1", 32'(bus.in_port), 32'h01);
        drive(0, 8'hF1, 8'h01, 1, 0, 0, 4'h0, 0); cyc();
        bus.write_strobe = 1'b0; cyc(); cyc();
        chk("seq_idle_int", 32'(bus.interrupt), 32'd0);
        chk("seq_pend0", 32'(bus.in_port), 32'h00);

        // Randomized run against the reference model
        drive(1, 8'h00, 8'h00, 0, 0, 0, 4'h0, 0);
        model_edge(); cyc();
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      bus.port_id = {4'($urandom_range(0, 3)), 4'($urandom)};
            else if (sel < 9) bus.port_id = {4'hF, 4'($urandom_range(0, 3))};
            else              bus.port_id = 8'($urandom);
            bus.out_port       = 8'($urandom);
            bus.write_strobe   = ($urandom_range(0, 3) == 0);
            bus.k_write_strobe = ($urandom_range(0, 9) == 0);
            bus.read_strobe    = ($urandom_range(0, 3) == 0);
            bus.interrupt_ack  = ($urandom_range(0, 3) == 0);
            irq_in             = ($urandom_range(0, 2) == 0) ? 4'($urandom) : irq_in;
            ch_rdata           = $urandom;
            rst                = ($urandom_range(0, 99) == 0);
            #1;
            chk("rnd_sel", 32'(ch_sel), 32'(sel_of(bus.port_id)));
            model_edge();
            cyc();
            chk("rnd_wr",    32'(ch_wr),         32'(m_wr));
            chk("rnd_rd",    32'(ch_rd),         32'(m_rd));
            chk("rnd_addr",  32'(ch_addr),       32'(m_addr));
            chk("rnd_wdata", 32'(ch_wdata),      32'(m_wdata));
            chk("rnd_inp",   32'(bus.in_port),   32'(m_inp));
            chk("rnd_int",   32'(bus.interrupt), 32'(m_phase == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
